set_job_issuer: RTL and testbench
=================================

# set_job_issuer

Initiator-side driver for the circle-set candidate counter (`SET`). It buffers incoming set-query jobs in a small FIFO and issues each job to `SET` with a one-cycle `en` pulse and stable operands. It waits for the matching `valid` pulse, or a timeout, and presents the captured `candidate` count on a ready/valid result port with a sequence tag. It sits between the host/test sequencer and `SET`, and it is the only block that drives `SET`'s `en`/`central`/`radius`/`mode`.

## Interface
- `DEPTH`, 4: job FIFO entries; power of 2, ≥2.
- `TIMEOUT`, 1023: maximum cycles in WAIT before the job is declared lost; must be ≤ 2^`TW`−1.
- `TW`, 10: width of the timeout counter.

- `clk` in 1: the only clock. All logic is rising-edge.
- `rst` in 1: reset is synchronous and active-high.
- `job_valid` in 1 / `job_ready` out 1: job push handshake.
- `job_central` in 24: {Ax,Ay,Bx,By,Cx,Cy}, 4 bits each.
- `job_radius` in 12: {Ra,Rb,Rc}, 4 bits each.
- `job_mode` in 2: set operation code, passed through unchanged.
- `set_en` out 1: start pulse to `SET`.
- `set_central` out 24, `set_radius` out 12, `set_mode` out 2: operands to `SET`.
- `set_busy` in 1, `set_valid` in 1, `set_candidate` in 8: status and result from `SET`.
- `res_valid` out 1 / `res_ready` in 1: result handshake.
- `res_candidate` out 8: captured count; 0 on timeout.
- `res_tag` out 4: issue sequence number of this result.
- `res_timeout` out 1: this result came from a timeout.
- `idle` out 1: FIFO empty, FSM in IDLE, and result slot empty.

## Operation
- **Job FIFO**
  - `job_ready` = !full, computed from the registered count only.
  - A push occurs on `job_valid & job_ready`.
  - Each entry holds 38 bits: central, radius, mode.
  - Pointers wrap modulo `DEPTH`.
  - Pop happens only on IDLE→ISSUE.
  - Simultaneous push and pop: count is unchanged and both pointers advance.
- **FSM** states: IDLE, ISSUE, WAIT.
  - IDLE→ISSUE when count≠0 & !`set_busy` & !`res_valid`. On this transition the head entry is loaded into the `set_*` operand registers and popped.
  - ISSUE: `set_en`=1 for exactly this one cycle. Always →WAIT. `tmo_cnt` is cleared.
  - WAIT, on `set_valid`=1: `res_candidate`←`set_candidate`, `res_timeout`←0, `res_valid`←1, →IDLE.
  - WAIT, otherwise: `tmo_cnt`++. When `tmo_cnt`==`TIMEOUT`: `res_candidate`←0, `res_timeout`←1, `res_valid`←1, →IDLE.
  - WAIT, if `set_valid` and the timeout condition occur in the same cycle: `set_valid` wins.
- **Ignored inputs**
  - `set_valid` in IDLE or ISSUE is ignored and no result is produced.
  - `set_busy` is consulted only in IDLE.
- **Operand hold**
  - `set_central`/`set_radius`/`set_mode` hold from ISSUE until the next IDLE→ISSUE transition; they never change mid-job.
- **Tag**
  - The `tag` counter increments on every ISSUE and wraps 15→0.
  - `res_tag` gets the tag of the issued job, captured at ISSUE and presented with the result.
- **Result slot** (single entry)
  - `res_valid` holds until `res_valid & res_ready`, and clears on the following edge.
  - `res_candidate`/`res_tag`/`res_timeout` are stable while `res_valid`=1.
  - No new job issues while `res_valid`=1. Because of this, a `SET` valid pulse is never dropped.

## Timing
- **Reset**: when `rst`=1 at an edge, the state becomes IDLE and the FIFO empties. The following are cleared to 0: `set_en`, `set_central`, `set_radius`, `set_mode`, `res_valid`, `res_candidate`, `res_tag`, `res_timeout`, `tag`, `tmo_cnt`.
  - After reset, `job_ready`=1 and `idle`=1.
  - Reset mid-WAIT abandons the job with no result produced.
- **First-issue latency**: job pushed at edge N (FIFO previously empty, `SET` not busy) → ISSUE state and `set_en`=1 during cycle N+1…N+2. Exactly: count becomes nonzero after edge N, IDLE→ISSUE at edge N+1, so `set_en` is high between edges N+1 and N+2.
- **Result latency**: `set_valid` sampled high in WAIT at edge M → `res_valid`=1 after edge M.
- **Back-to-back jobs**: the result is consumed at edge M+k. The next ISSUE can occur at edge M+k+1 at the earliest.
- **Timeout**: `res_valid` rises `TIMEOUT`+1 edges after ISSUE if no `set_valid` arrives.
- **Full FIFO**: `job_ready`=0, and a push is refused even if a pop occurs in the same cycle.

## Test plan
- **Single job**: reset, then push central=0x123456, radius=0x333, mode=0. Model `SET` raises busy 1 cycle after `en` and pulses valid with candidate=17 eight cycles later. Required: one `set_en` pulse with operands equal to the pushed job; `res_valid`=1 with candidate=17, tag=0, timeout=0; `idle`=1 after `res_ready`.
- **Fill and backpressure**: push 5 jobs with `SET` held busy. Required: `job_ready`=0 after the 4th push; the 5th is accepted only after the first ISSUE. Results come out in push order with tags 0..4.
- **Result stall**: hold `res_ready`=0 for 20 cycles with 3 jobs queued. Required: no `set_en` while `res_valid`=1; the first result stays stable; the remaining jobs issue one at a time after each consume.
- **Timeout**: `SET` model never returns valid, `TIMEOUT`=15. Required: `res_valid` exactly 16 edges after ISSUE with candidate=0 and `res_timeout`=1. Also fire valid on the timeout edge → `res_timeout`=0 and the real candidate is returned.
- **Stray valid / tag wrap**: pulse `set_valid` in IDLE → no result. Run 17 jobs → tags 0..15 then 0.
- **Reset mid-WAIT**: assert `rst` two cycles after `set_en`. Required: all outputs return to reset values, FIFO empty, and no result emitted.

Source files
------------

// File: rtl/set_job_issuer.sv
// Initiator-side driver for the SET candidate counter: queues set-query jobs,
// issues them one at a time, and returns each count (or a timeout) with a tag.
module set_job_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [23:0] job_central,
  input  logic [11:0] job_radius,
  input  logic [1:0]  job_mode,
  output logic        set_en,
  output logic [23:0] set_central,
  output logic [11:0] set_radius,
  output logic [1:0]  set_mode,
  input  logic        set_busy,
  input  logic        set_valid,
  input  logic [7:0]  set_candidate,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_candidate,
  output logic [3:0]  res_tag,
  output logic        res_timeout,
  output logic        idle
);

  localparam int unsigned AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t         state, state_nxt;
  logic [37:0]    mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic [3:0]     tag, job_tag;
  logic [TW-1:0]  tmo_cnt;
  logic           push, pop, tmo_hit;

  assign job_ready = (count != (AW+1)'(DEPTH));
  assign push      = job_valid & job_ready;
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT));
  assign set_en    = (state == ISSUE);
  assign idle      = (count == '0) && (state == IDLE) && !res_valid;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0 && !set_busy && !res_valid) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (set_valid || tmo_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {job_central, job_radius, job_mode};
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      set_central   <= '0;
      set_radius    <= '0;
      set_mode      <= '0;
      tag           <= '0;
      job_tag       <= '0;
      tmo_cnt       <= '0;
      res_valid     <= 1'b0;
      res_candidate <= '0;
      res_tag       <= '0;
      res_timeout   <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) {set_central, set_radius, set_mode} <= mem[rd_ptr];
        end
        ISSUE: begin
          tmo_cnt <= '0;
          job_tag <= tag;
          tag     <= tag + 4'd1;
        end
        WAIT: begin
          // A response arriving on the timeout cycle is still delivered as real.
          if (set_valid) begin
            res_valid     <= 1'b1;
            res_candidate <= set_candidate;
            res_timeout   <= 1'b0;
            res_tag       <= job_tag;
          end else if (tmo_hit) begin
            res_valid     <= 1'b1;
            res_candidate <= '0;
            res_timeout   <= 1'b1;
            res_tag       <= job_tag;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_set_job_issuer.sv
// Bench for set_job_issuer: drives jobs and a behavioural SET responder, and
// checks every issue and result against a job-queue / tag-count reference.
module tb_set_job_issuer;

  localparam int unsigned TMO = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid, job_ready;
  logic [23:0] job_central;
  logic [11:0] job_radius;
  logic [1:0]  job_mode;
  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_busy, set_valid;
  logic [7:0]  set_candidate;
  logic        res_valid, res_ready;
  logic [7:0]  res_candidate;
  logic [3:0]  res_tag;
  logic        res_timeout, idle;

  always #5 clk = ~clk;

  set_job_issuer #(.DEPTH(4), .TIMEOUT(TMO), .TW(10)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_central(job_central), .job_radius(job_radius), .job_mode(job_mode),
    .set_en(set_en), .set_central(set_central), .set_radius(set_radius), .set_mode(set_mode),
    .set_busy(set_busy), .set_valid(set_valid), .set_candidate(set_candidate),
    .res_valid(res_valid), .res_ready(res_ready), .res_candidate(res_candidate),
    .res_tag(res_tag), .res_timeout(res_timeout), .idle(idle)
  );

  int passed = 0, total = 0, fails = 0;
  int cyc = 0;

  // SET responder controls and state
  int          lat = 0;
  bit          never = 1'b0, hold_busy = 1'b0;
  logic [7:0]  cand = '0;
  int          stray_cnt = 0, stray_done = 0;
  bit          pending = 1'b0, m_never = 1'b0;
  int          mcnt = 0;
  logic [7:0]  m_cand = '0;

  // Reference model
  logic [37:0] jq[$];
  logic [3:0]  tags_out[$];
  int unsigned tag_ref = 0;
  bit          inflight = 1'b0, res_seen = 1'b0, exp_never = 1'b0;
  int          issue_cyc = 0, exp_lat = 0;
  logic [7:0]  exp_cand = '0, h_cand = '0;
  logic [3:0]  exp_tag = '0, h_tag = '0;
  logic        h_tmo = 1'b0;
  int          results = 0, accepted = 0, issues = 0, last_push_edge = 0, issues_at_push = 0;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic model_step();
    set_valid = 1'b0;
    if (rst) begin
      pending  = 1'b0;
      set_busy = 1'b0;
      return;
    end
    if (stray_cnt != stray_done) begin
      set_valid     = 1'b1;
      set_candidate = 8'hEE;
      stray_done    = stray_cnt;
    end
    if (pending) begin
      if (mcnt == 0) begin
        pending = 1'b0;
        if (!m_never) begin
          set_valid     = 1'b1;
          set_candidate = m_cand;
        end
      end else mcnt--;
    end
    if (set_en) begin
      pending = 1'b1;
      mcnt    = lat;
      m_never = never;
      m_cand  = cand;
    end
    set_busy = hold_busy | pending;
  endtask

  task automatic monitor();
    bit ok;
    int exp_dly;
    if (rst) return;
    if (set_en) begin
      issues++;
      chk("en_while_result", res_valid, 0);
      chk("en_has_job", jq.size() != 0, 1);
      if (jq.size() != 0) chk("en_operands", {set_central, set_radius, set_mode}, jq.pop_front());
      inflight  = 1'b1;
      issue_cyc = cyc;
      exp_tag   = 4'(tag_ref);
      tag_ref   = (tag_ref + 1) % 16;
      exp_lat   = lat;
      exp_never = never;
      exp_cand  = cand;
    end
    if (res_seen) begin
      chk("res_hold", res_valid, 1);
      chk("res_stable", {res_candidate, res_tag, res_timeout}, {h_cand, h_tag, h_tmo});
    end else if (res_valid) begin
      chk("res_expected", inflight, 1);
      ok      = !exp_never && (exp_lat <= int'(TMO));
      exp_dly = ok ? exp_lat + 2 : int'(TMO) + 2;
      chk("res_latency", cyc - issue_cyc, exp_dly);
      chk("res_candidate", res_candidate, ok ? exp_cand : 8'h00);
      chk("res_timeout", res_timeout, !ok);
      chk("res_tag", res_tag, exp_tag);
      inflight = 1'b0;
      res_seen = 1'b1;
      h_cand   = res_candidate;
      h_tag    = res_tag;
      h_tmo    = res_timeout;
    end
  endtask

  task automatic tick();
    if (!rst) begin
      if (job_valid && job_ready) begin
        jq.push_back({job_central, job_radius, job_mode});
        accepted++;
        last_push_edge = cyc + 1;
        issues_at_push = issues;
      end
      if (res_valid && res_ready) begin
        results++;
        tags_out.push_back(res_tag);
        res_seen = 1'b0;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    model_step();
    @(negedge clk);
    monitor();
  endtask

  task automatic clear_ref();
    jq.delete();
    tags_out.delete();
    tag_ref  = 0;
    inflight = 1'b0;
    res_seen = 1'b0;
    results  = 0;
    accepted = 0;
    issues   = 0;
  endtask

  task automatic chk_reset();
    chk("rst_set_en", set_en, 0);
    chk("rst_operands", {set_central, set_radius, set_mode}, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_fields", {res_candidate, res_tag, res_timeout}, 0);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_idle", idle, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1; job_valid = 1'b0; res_ready = 1'b0; hold_busy = 1'b0; never = 1'b0;
    tick();
    tick();
    chk_reset();
    rst = 1'b0;
    clear_ref();
  endtask

  task automatic push(input logic [23:0] c, input logic [11:0] r, input logic [1:0] m);
    int a;
    a = accepted;
    job_central = c; job_radius = r; job_mode = m; job_valid = 1'b1;
    for (int i = 0; i < 200 && accepted == a; i++) tick();
    chk("push_accepted", accepted, a + 1);
    job_valid = 1'b0;
  endtask

  task automatic push_rand();
    push(24'($urandom), 12'($urandom), 2'($urandom));
  endtask

  task automatic wait_results(input int n);
    for (int i = 0; i < 600 && results < n; i++) tick();
    chk("results_count", results, n);
  endtask

  task automatic wait_res_valid();
    for (int i = 0; i < 100 && !res_valid; i++) tick();
    chk("res_arrived", res_valid, 1);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_central = '0; job_radius = '0; job_mode = '0;
    set_busy = 1'b0; set_valid = 1'b0; set_candidate = '0; res_ready = 1'b0;

    // Single job
    do_reset();
    lat = 8; cand = 8'd17;
    push(24'h123456, 12'h333, 2'd0);
    wait_res_valid();
    chk("first_issue_latency", issue_cyc, last_push_edge + 1);
    chk("single_cand", res_candidate, 8'd17);
    chk("single_tag", res_tag, 0);
    chk("single_tmo", res_timeout, 0);
    res_ready = 1'b1;
    wait_results(1);
    res_ready = 1'b0;
    tick();
    chk("single_idle", idle, 1);

    // Fill and backpressure
    do_reset();
    hold_busy = 1'b1; res_ready = 1'b1; lat = 2; cand = 8'h40;
    for (int i = 0; i < 4; i++) push_rand();
    chk("full_ready", job_ready, 0);
    job_central = 24'($urandom); job_radius = 12'($urandom); job_mode = 2'($urandom);
    job_valid = 1'b1;
    repeat (5) tick();
    chk("full_refused", accepted, 4);
    hold_busy = 1'b0;
    for (int i = 0; i < 50 && accepted < 5; i++) tick();
    job_valid = 1'b0;
    chk("fifth_accepted", accepted, 5);
    chk("fifth_after_issue", issues_at_push >= 1, 1);
    wait_results(5);
    for (int i = 0; i < 5; i++) chk("fill_tag_order", tags_out[i], i);

    // Result stall
    do_reset();
    lat = 3; cand = 8'h99; res_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_rand();
    wait_res_valid();
    repeat (20) tick();
    chk("stall_hold", res_valid, 1);
    chk("stall_issues", issues, 1);
    res_ready = 1'b1;
    wait_results(3);
    for (int i = 0; i < 3; i++) chk("stall_tag_order", tags_out[i], i);

    // Timeout, valid on the timeout edge, valid after the timeout
    do_reset();
    never = 1'b1; lat = 0;
    push_rand();
    wait_res_valid();
    chk("tmo_latency", cyc - issue_cyc, TMO + 2);
    chk("tmo_cand", res_candidate, 0);
    chk("tmo_flag", res_timeout, 1);
    res_ready = 1'b1;
    wait_results(1);
    res_ready = 1'b0; never = 1'b0; lat = TMO; cand = 8'h5A;
    push_rand();
    wait_res_valid();
    chk("edge_valid_flag", res_timeout, 0);
    chk("edge_valid_cand", res_candidate, 8'h5A);
    res_ready = 1'b1;
    wait_results(2);
    lat = TMO + 1; cand = 8'hC3;
    push_rand();
    wait_results(3);
    repeat (6) tick();
    chk("late_valid_ignored", results, 3);

    // Stray valid in IDLE, then tag wrap over 17 random jobs
    do_reset();
    stray_cnt++;
    repeat (6) tick();
    chk("stray_no_result", res_valid, 0);
    chk("stray_idle", idle, 1);
    res_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      lat  = $urandom_range(0, 18);
      cand = 8'($urandom);
      push_rand();
      wait_results(i + 1);
    end
    for (int i = 0; i < 17; i++) chk("wrap_tag", tags_out[i], i % 16);

    // Reset mid-WAIT
    do_reset();
    lat = 10; cand = 8'h77; res_ready = 1'b1;
    push_rand();
    for (int i = 0; i < 20 && issues == 0; i++) tick();
    chk("mid_issued", issues, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset();
    rst = 1'b0;
    clear_ref();
    repeat (20) tick();
    chk("mid_no_result", results, 0);
    chk("mid_idle", idle, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
